// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/stall/flush controller with multi-cycle op FSM; PIPE_CTRL_PERF_EN builds perf counters
module pipe_ctrl #(
  parameter int MDV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_rs1_en_i,
  input  logic        dec_rs2_en_i,
  input  logic [4:0]  dec_rs1_idx_i,
  input  logic [4:0]  dec_rs2_idx_i,
  input  logic        id_ex_rd_en_i,
  input  logic [4:0]  id_ex_rd_idx_i,
  input  logic        id_ex_is_load_i,
  input  logic        ex_pipe_flush_i,
  input  logic        ex_mdv_start_i,
  input  logic        ex_mdv_done_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        mdv_busy_o,
  output logic        mdv_abort_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  typedef enum logic {IDLE, MDV} state_t;
  localparam logic [7:0] TMO = 8'(MDV_TIMEOUT);
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic lu, mdv_stall, lu_stall, if_id_f, id_ex_f, ex_mem_f, abort;
  // state and MDV cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // next state and raw controls: flush beats MDV, MDV beats load-use
  always_comb begin
    lu = id_ex_is_load_i & id_ex_rd_en_i & (id_ex_rd_idx_i != 5'd0) &
         ((dec_rs1_en_i & (dec_rs1_idx_i == id_ex_rd_idx_i)) |
          (dec_rs2_en_i & (dec_rs2_idx_i == id_ex_rd_idx_i)));
    state_nx = state;
    cnt_nx = cnt;
    mdv_stall = 1'b0;
    lu_stall = 1'b0;
    if_id_f = 1'b0;
    id_ex_f = 1'b0;
    ex_mem_f = 1'b0;
    abort = 1'b0;
    if (ex_pipe_flush_i) begin
      if_id_f = 1'b1;
      id_ex_f = 1'b1;
      abort = state == MDV;
      state_nx = IDLE;
    end else if (state == MDV) begin
      if (ex_mdv_done_i) begin
        state_nx = IDLE;
      end else if (cnt >= TMO) begin
        abort = 1'b1;
        id_ex_f = 1'b1;
        state_nx = IDLE;
      end else begin
        mdv_stall = 1'b1;
        ex_mem_f = 1'b1;
        cnt_nx = cnt + 8'd1;
      end
    end else if (ex_mdv_start_i) begin
      if (!ex_mdv_done_i) begin
        mdv_stall = 1'b1;
        ex_mem_f = 1'b1;
        state_nx = MDV;
        cnt_nx = 8'd1;
      end
    end else if (lu) begin
      lu_stall = 1'b1;
      id_ex_f = 1'b1;
    end
  end
  assign pc_stall_o     = !rst & (mdv_stall | lu_stall);
  assign if_id_stall_o  = !rst & (mdv_stall | lu_stall);
  assign id_ex_stall_o  = !rst & mdv_stall;
  assign if_id_flush_o  = !rst & if_id_f;
  assign id_ex_flush_o  = !rst & id_ex_f;
  assign ex_mem_flush_o = !rst & ex_mem_f;
  assign mdv_busy_o     = !rst & (state == MDV);
  assign mdv_abort_o    = !rst & abort;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  // saturating stall / redirect counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall_o && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (ex_pipe_flush_i && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
  assign stall_cnt_o = rst ? '0 : stall_cnt;
  assign flush_cnt_o = rst ? '0 : flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed literal checks plus randomized run against a behavioural model
module tb_pipe_ctrl;
  localparam int T = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic rs1_en, rs2_en, rd_en, is_load, flush, start, done;
  logic [4:0] rs1, rs2, rd;
  logic pc_s, if_id_s, id_ex_s, if_id_f, id_ex_f, ex_mem_f, busy, abort;
  logic [31:0] stall_cnt, flush_cnt;
  logic [7:0] outv;
  int total = 0, passed = 0;
  bit m_busy = 0;
  int m_age = 0;
  longint m_sc = 0, m_fc = 0;
  logic [7:0] e;
  logic [63:0] ec;
  logic lu;
  bit nb;
  int na;

  pipe_ctrl #(.MDV_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .dec_rs1_en_i(rs1_en), .dec_rs2_en_i(rs2_en),
    .dec_rs1_idx_i(rs1), .dec_rs2_idx_i(rs2),
    .id_ex_rd_en_i(rd_en), .id_ex_rd_idx_i(rd), .id_ex_is_load_i(is_load),
    .ex_pipe_flush_i(flush), .ex_mdv_start_i(start), .ex_mdv_done_i(done),
    .pc_stall_o(pc_s), .if_id_stall_o(if_id_s), .id_ex_stall_o(id_ex_s),
    .if_id_flush_o(if_id_f), .id_ex_flush_o(id_ex_f), .ex_mem_flush_o(ex_mem_f),
    .mdv_busy_o(busy), .mdv_abort_o(abort),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;
  assign outv = {pc_s, if_id_s, id_ex_s, if_id_f, id_ex_f, ex_mem_f, busy, abort};

  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", n, $time, got, exp);
  endtask

  task automatic clr();
    {rs1_en, rs2_en, rd_en, is_load, flush, start, done} = '0;
    {rs1, rs2, rd} = '0;
  endtask

  task automatic set_lu(input logic [4:0] r, input logic en2);
    is_load = 1'b1; rd_en = 1'b1; rd = r; rs2_en = en2; rs2 = 5'd5; rs1_en = 1'b1; rs1 = 5'd7;
  endtask

  task automatic chk_cyc(input string n, input logic [7:0] exp);
    #3 check(n, {56'd0, outv}, {56'd0, exp});
    @(posedge clk); #1;
    clr();
  endtask

  // reference model: outputs follow from the current inputs and the age of the running mul/div op
  always @(negedge clk) begin
    e = '0; nb = m_busy; na = m_age;
    lu = is_load & rd_en & (rd != 0) & ((rs1_en & (rs1 == rd)) | (rs2_en & (rs2 == rd)));
    if (rst) nb = 0;
    else begin
      if (flush) begin e[4] = 1; e[3] = 1; e[0] = m_busy; nb = 0; end
      else if (m_busy) begin
        if (done) nb = 0;
        else if (m_age == T) begin e[0] = 1; e[3] = 1; nb = 0; end
        else begin e[7:5] = 3'b111; e[2] = 1; na = m_age + 1; end
      end else if (start) begin
        if (!done) begin e[7:5] = 3'b111; e[2] = 1; nb = 1; na = 1; end
      end else if (lu) begin e[7] = 1; e[6] = 1; e[3] = 1; end
      e[1] = m_busy;
    end
    check("model_outputs", {56'd0, outv}, {56'd0, e});
`ifdef PIPE_CTRL_PERF_EN
    ec = rst ? 64'd0 : {m_sc[31:0], m_fc[31:0]};
`else
    ec = 64'd0;
`endif
    check("model_counters", {stall_cnt, flush_cnt}, ec);
    if (rst) begin m_sc = 0; m_fc = 0; end
    else begin m_sc += longint'(e[7]); m_fc += longint'(flush); end
    m_busy = nb; m_age = na;
  end

  initial begin
    clr();
    @(posedge clk); #1;
    chk_cyc("reset", 8'h00);
    rst = 1'b0;
    set_lu(5'd5, 1'b1); chk_cyc("lu_stall", 8'hC8);
    chk_cyc("lu_release", 8'h00);
    set_lu(5'd0, 1'b1); rs2 = 5'd0; chk_cyc("lu_x0", 8'h00);
    set_lu(5'd5, 1'b0); chk_cyc("lu_no_en", 8'h00);
    start = 1; chk_cyc("mdv_start", 8'hE4);
    repeat (3) chk_cyc("mdv_hold", 8'hE6);
    done = 1; chk_cyc("mdv_done", 8'h02);
    chk_cyc("mdv_idle", 8'h00);
    start = 1; chk_cyc("tmo_start", 8'hE4);
    repeat (T - 1) chk_cyc("tmo_hold", 8'hE6);
    chk_cyc("tmo_abort", 8'h0B);
    chk_cyc("tmo_idle", 8'h00);
    start = 1; done = 1; chk_cyc("start_done", 8'h00);
    set_lu(5'd5, 1'b1); flush = 1; chk_cyc("flush_lu", 8'h18);
    start = 1; chk_cyc("fl_start", 8'hE4);
    flush = 1; done = 1; chk_cyc("mdv_flush", 8'h1B);
    chk_cyc("fl_idle", 8'h00);
    start = 1; chk_cyc("rst_start", 8'hE4);
    chk_cyc("rst_hold", 8'hE6);
    rst = 1; chk_cyc("rst_mdv", 8'h00);
    rst = 0; chk_cyc("after_rst", 8'h00);
    repeat (3) begin set_lu(5'd5, 1'b1); chk_cyc("perf_lu", 8'hC8); end
    repeat (2) begin flush = 1; chk_cyc("perf_flush", 8'h18); end
    #3;
`ifdef PIPE_CTRL_PERF_EN
    check("perf_counts", {stall_cnt, flush_cnt}, {32'd3, 32'd2});
`else
    check("perf_counts", {stall_cnt, flush_cnt}, 64'd0);
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      flush = $urandom_range(0, 11) == 0;
      start = $urandom_range(0, 4) == 0;
      done = $urandom_range(0, 5) == 0;
      is_load = $urandom_range(0, 1) == 1;
      rd_en = $urandom_range(0, 3) != 0;
      rs1_en = $urandom_range(0, 1) == 1;
      rs2_en = $urandom_range(0, 1) == 1;
      rd = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
- REQ-001: Parameter MDV_TIMEOUT, default 64: maximum MDV-state cycles before abort; legal range 2..255.
- REQ-002: clk  input  1  core clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: dec_rs1_en_i / dec_rs2_en_i  input  1 each  ID source-operand valid.
- REQ-005: dec_rs1_idx_i / dec_rs2_idx_i  input  5 each  ID source register index.
- REQ-006: id_ex_rd_en_i  input  1  EX instruction writes rd.
- REQ-007: id_ex_rd_idx_i  input  5  EX destination index.
- REQ-008: id_ex_is_load_i  input  1  EX instruction is a load.
- REQ-009: ex_pipe_flush_i  input  1  EX redirect (mispredict/jump).
- REQ-010: ex_mdv_start_i  input  1  EX holds a multi-cycle (mul/div) op, first cycle.
- REQ-011: ex_mdv_done_i  input  1  multi-cycle result valid this cycle.
- REQ-012: pc_stall_o, if_id_stall_o, id_ex_stall_o  output  1 each  hold register.
- REQ-013: if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  output  1 each  load bubble next edge.
- REQ-014: mdv_busy_o  output  1  FSM in MDV.
- REQ-015: mdv_abort_o  output  1  one-cycle pulse: multi-cycle op killed (timeout or flush).
- REQ-016: stall_cnt_o, flush_cnt_o  output  32 each  performance counters.

Function
- REQ-017: FSM states IDLE, MDV; rest/reset state IDLE.
- REQ-018: Load-use hazard LU = id_ex_is_load_i & id_ex_rd_en_i & rd_idx!=0 & ((rs1_en & rs1_idx==rd_idx) | (rs2_en & rs2_idx==rd_idx)); evaluated in IDLE only.
- REQ-019: Priority per cycle: flush > MDV start/hold > LU.
- REQ-020: Flush (any state): if_id_flush_o=id_ex_flush_o=1, all stalls 0, same cycle (combinational, 0 latency).
- REQ-021: IDLE & LU & !flush & !mdv_start: pc_stall_o=if_id_stall_o=1, id_ex_flush_o=1 for exactly that cycle; stays IDLE.
- REQ-022: IDLE & mdv_start & !done & !flush: pc/if_id/id_ex stall=1, ex_mem_flush_o=1, next state MDV, timeout counter cleared to 1.
- REQ-023: IDLE & mdv_start & done same cycle: no stall, stays IDLE.
- REQ-024: MDV & !done & !flush & counter<MDV_TIMEOUT: stalls and ex_mem_flush_o held 1, counter increments.
- REQ-025: MDV & done: all stalls and ex_mem_flush_o 0 that cycle (result captured by ex_mem), next IDLE.
- REQ-026: MDV & flush (done ignored): flush outputs per REQ-020, mdv_abort_o=1, next IDLE.
- REQ-027: MDV & counter==MDV_TIMEOUT & !done: mdv_abort_o=1, id_ex_flush_o=1, stalls 0, next IDLE.
- REQ-028: mdv_busy_o = (state==MDV), registered.

Reset
- REQ-029: rst=1 at edge: state IDLE, counter 0, perf counters 0; all outputs 0 while rst asserted, including mid-MDV (no abort pulse).

Configuration
- REQ-030: Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o increments each cycle pc_stall_o=1, flush_cnt_o each cycle ex_pipe_flush_i=1; both saturate at 0xFFFF_FFFF.
- REQ-031: PIPE_CTRL_PERF_EN undefined: counters not built, both outputs constant 0.

Verification
- REQ-032: EX lw rd=x5 load, ID rs2=x5 en -> one cycle pc_stall=if_id_stall=id_ex_flush=1, then 0.
- REQ-033: Same as REQ-032 but rd=x0, or rs2_en=0 -> no stall, no flush.
- REQ-034: mdv_start, done 4 cycles later -> stalls 1 for 4 cycles, released on done cycle, mdv_busy 1 for 4 cycles.
- REQ-035: MDV_TIMEOUT=8, mdv_start, no done -> abort pulse on 8th MDV cycle, id_ex_flush=1, IDLE next.
- REQ-036: ex_pipe_flush with LU simultaneously -> flush outputs only, no stall; during MDV -> abort pulse; rst mid-MDV -> IDLE, outputs 0.
- REQ-037: PERF_EN build, 3 LU stalls + 2 flushes -> stall_cnt=3, flush_cnt=2; non-PERF build -> both 0.
